// File: rtl/pipeline_interlock.sv
// Hazard interlock and forwarding-select unit beside decode; tracks DEPTH in-flight destinations.
// Define PIPELINE_INTERLOCK_FWD_EN to enable operand forwarding (only load-use hazards stall).
module pipeline_interlock #(
    parameter  int DEPTH = 3,
    parameter  int REG_W = 5,
    localparam int FW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             flush,
    output logic             stall,
    output logic [FW-1:0]    fwd_a,
    output logic [FW-1:0]    fwd_b,
    output logic [DEPTH-1:0] inflight,
    output logic [15:0]      stall_cnt
);

    // Index k holds slot k+1: index 0 is EX (youngest), index DEPTH-1 is WB (oldest).
    logic [DEPTH-1:0] slot_vld;
    logic [REG_W-1:0] slot_rd [DEPTH];
    logic [DEPTH-1:0] slot_ld;

    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;
    logic             active;
    logic             hazard;
    logic             issue;
    logic [15:0]      cnt;
    logic             unused_ld;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [FW-1:0] youngest(input logic [DEPTH-1:0] hit);
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (hit[k]) sel = FW'(k + 1);
        end
        return sel;
    endfunction

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_a[k] = id_rs1_used && (id_rs1 != '0) && slot_vld[k] && (slot_rd[k] == id_rs1);
            hit_b[k] = id_rs2_used && (id_rs2 != '0) && slot_vld[k] && (slot_rd[k] == id_rs2);
        end
    end

    // A squashed or absent decode instruction never stalls, forwards or issues.
    assign active = id_valid && !flush;

`ifdef PIPELINE_INTERLOCK_FWD_EN
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;

    assign sel_a  = youngest(hit_a);
    assign sel_b  = youngest(hit_b);
    assign hazard = ((sel_a == FW'(1)) || (sel_b == FW'(1))) && slot_ld[0];
    assign fwd_a  = active ? sel_a : '0;
    assign fwd_b  = active ? sel_b : '0;
`else
    // No write-through in the register file: wait until the producer has left WB.
    assign hazard = (|hit_a) || (|hit_b);
    assign fwd_a  = '0;
    assign fwd_b  = '0;
`endif

    assign stall     = active && hazard;
    assign issue     = active && !hazard && id_we && (id_rd != '0);
    assign inflight  = slot_vld;
    assign stall_cnt = cnt;
    assign unused_ld = ^slot_ld;

    // Slot valid chain and stall counter: shift every edge, never frozen by a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            cnt      <= '0;
        end else begin
            slot_vld[0] <= issue;
            for (int k = DEPTH - 1; k > 0; k--) begin
                slot_vld[k] <= slot_vld[k-1];
            end
            if (stall) cnt <= sat_inc16(cnt);
        end
    end

    // Slot payload is qualified by slot_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_rd[0] <= id_rd;
        slot_ld[0] <= id_is_load;
        for (int k = DEPTH - 1; k > 0; k--) begin
            slot_rd[k] <= slot_rd[k-1];
            slot_ld[k] <= slot_ld[k-1];
        end
    end

endmodule

// File: tb/tb_pipeline_interlock.sv
// Scoreboard bench for pipeline_interlock: directed vectors on a DEPTH=3 instance plus a
// long-running DEPTH=7 instance for stall-counter saturation. Follows PIPELINE_INTERLOCK_FWD_EN.
module tb_pipeline_interlock;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, DEPTH = 3
    logic        rst_n;
    logic        id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall;
    logic [1:0]  fwd_a, fwd_b;
    logic [2:0]  inflight;
    logic [15:0] stall_cnt;

    // Saturation instance, DEPTH = 7
    logic        rst2_n;
    logic        s_valid, s_rs1_used, s_rs2_used, s_we, s_is_load, s_flush;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic        s_stall;
    logic [2:0]  s_fwd_a, s_fwd_b;
    logic [6:0]  s_inflight;
    logic [15:0] s_cnt;

    pipeline_interlock #(.DEPTH(3), .REG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .inflight(inflight), .stall_cnt(stall_cnt)
    );

    pipeline_interlock #(.DEPTH(7), .REG_W(5)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .id_valid(s_valid),
        .id_rs1(s_rs1), .id_rs1_used(s_rs1_used),
        .id_rs2(s_rs2), .id_rs2_used(s_rs2_used),
        .id_rd(s_rd), .id_we(s_we), .id_is_load(s_is_load), .flush(s_flush),
        .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .inflight(s_inflight), .stall_cnt(s_cnt)
    );

    // Expected response; a field of -1 is not checked.
    typedef struct {
        int    inst;
        string nm;
        int    es;
        int    efa;
        int    efb;
        int    ei;
        int    ec;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_one(input exp_t e, input int st, input int fa, input int fb,
                             input int inf, input int cn);
        if (e.es >= 0) begin
            chk({e.nm, ".stall"}, st, e.es);
            chk({e.nm, ".fwd_a"}, fa, e.efa);
            chk({e.nm, ".fwd_b"}, fb, e.efb);
        end
        if (e.ei >= 0) chk({e.nm, ".inflight"}, inf, e.ei);
        if (e.ec >= 0) chk({e.nm, ".stall_cnt"}, cn, e.ec);
    endtask

    // Monitor: everything queued since the last edge is compared mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            me = sb.pop_front();
            if (me.inst == 0)
                check_one(me, int'(stall), int'(fwd_a), int'(fwd_b), int'(inflight), int'(stall_cnt));
            else
                check_one(me, int'(s_stall), int'(s_fwd_a), int'(s_fwd_b), int'(s_inflight), int'(s_cnt));
        end
    end

    task automatic push(input int inst, input string nm, input int es, input int efa,
                        input int efb, input int ei, input int ec);
        exp_t e;
        e.inst = inst; e.nm = nm; e.es = es; e.efa = efa; e.efb = efb; e.ei = ei; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                         input int rd, input int we, input int ld, input int fl);
        id_valid    = (v != 0);
        id_rs1      = 5'(rs1);
        id_rs1_used = (u1 != 0);
        id_rs2      = 5'(rs2);
        id_rs2_used = (u2 != 0);
        id_rd       = 5'(rd);
        id_we       = (we != 0);
        id_is_load  = (ld != 0);
        flush       = (fl != 0);
    endtask

    // One decode cycle on the main instance with its expected response.
    task automatic cyc(input string nm, input int v, input int rs1, input int u1, input int rs2,
                       input int u2, input int rd, input int we, input int ld, input int fl,
                       input int es, input int efa, input int efb, input int ei, input int ec);
        @(posedge clk); #1;
        drive(v, rs1, u1, rs2, u2, rd, we, ld, fl);
        push(0, nm, es, efa, efb, ei, ec);
    endtask

    task automatic idle(input string nm, input int ei, input int ec);
        cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ei, ec);
    endtask

    task automatic run_main();
        int bc;
        idle("rst_state", 0, 0);
`ifdef PIPELINE_INTERLOCK_FWD_EN
        cyc("fw_wr5",   1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        cyc("fw_dep1",  1, 5, 1, 0, 0, 6, 1, 0, 0,   0, 1, 0, 1, 0);
        cyc("fw_dep2",  1, 5, 1, 6, 1, 0, 0, 0, 0,   0, 2, 1, 3, 0);
        idle("fw_i1", 6, 0);
        cyc("fw_wr5b",  1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 4, 0);
        cyc("fw_both",  1, 5, 1, 5, 1, 0, 0, 0, 0,   0, 1, 1, 1, 0);
        idle("fw_i2", 2, 0);
        cyc("fw_ld7",   1, 0, 0, 0, 0, 7, 1, 1, 0,   0, 0, 0, 4, 0);
        cyc("fw_lu1",   1, 0, 0, 7, 1, 0, 0, 0, 0,   1, 0, 1, 1, 0);
        cyc("fw_lu2",   1, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 2, 2, 1);
        idle("fw_i3", 4, 1);
        cyc("fw_ld7b",  1, 0, 0, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0, 1);
        cyc("fw_alu7",  1, 0, 0, 0, 0, 7, 1, 0, 0,   0, 0, 0, 1, 1);
        cyc("fw_young", 1, 0, 0, 7, 1, 0, 0, 0, 0,   0, 0, 1, 3, 1);
        idle("fw_i4", 6, 1);
        idle("fw_i5", 4, 1);
        idle("fw_i6", 0, 1);
        bc = 1;
`else
        cyc("nf_wr5",   1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0);
        cyc("nf_raw1",  1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0);
        cyc("nf_raw2",  1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 2, 1);
        cyc("nf_raw3",  1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 4, 2);
        cyc("nf_issue", 1, 5, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 3);
        idle("nf_after", 0, 3);
        bc = 3;
`endif
        cyc("wr5b",        1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, bc);
        cyc("novalid_haz", 0, 5, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, bc);
        idle("nv_i1", 2, bc);
        idle("nv_i2", 4, bc);
        cyc("rd0_wr",      1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, bc);
        cyc("rd0_use",     1, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, bc);
        cyc("fl_ld6",      1, 0, 0, 0, 0, 6, 1, 1, 0,   0, 0, 0, 0, bc);
        cyc("fl_haz",      1, 0, 0, 6, 1, 9, 1, 0, 1,   0, 0, 0, 1, bc);
        idle("fl_after", 2, bc);
        idle("fl_i1", 4, bc);
        idle("fl_i2", 0, bc);
        cyc("wr1",         1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, bc);
        cyc("wr2",         1, 0, 0, 0, 0, 2, 1, 0, 0,   0, 0, 0, 1, bc);
        cyc("wr3",         1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 3, bc);
        idle("full", 7, bc);
        // Asynchronous reset mid-stream: outputs must clear before the next edge.
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        push(0, "async_rst", 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push(0, "rst_release", 0, 0, 0, 0, 0);
        cyc("post_rst_dep", 1, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
        idle("end_idle", 0, 0);
    endtask

    // Constant decode instruction that depends on its own destination keeps the
    // second instance stalling as often as the configuration allows.
    task automatic run_sat();
        int nstall = 0;
        int ns;
        int es;
        int efb;
        int ec;
`ifdef PIPELINE_INTERLOCK_FWD_EN
        ns = 2000;
`else
        ns = 75000;
`endif
        for (int i = 0; i < ns; i++) begin
            @(posedge clk); #1;
            s_valid = 1'b1;
            s_flush = 1'b0;
            s_we    = 1'b1;
`ifdef PIPELINE_INTERLOCK_FWD_EN
            s_rs1 = 5'd0;  s_rs1_used = 1'b0;
            s_rs2 = 5'd7;  s_rs2_used = 1'b1;
            s_rd  = 5'd7;  s_is_load  = 1'b1;
            es  = i % 2;
            efb = (i == 0) ? 0 : ((es != 0) ? 1 : 2);
`else
            s_rs1 = 5'd5;  s_rs1_used = 1'b1;
            s_rs2 = 5'd0;  s_rs2_used = 1'b0;
            s_rd  = 5'd5;  s_is_load  = 1'b0;
            es  = (i % 8 != 0) ? 1 : 0;
            efb = 0;
`endif
            ec = -1;
            if ((i % 4096 == 0) || (nstall >= 65530 && nstall <= 65540) || (i >= ns - 3))
                ec = (nstall > 65535) ? 65535 : nstall;
            push(1, "sat", es, 0, efb, -1, ec);
            nstall += es;
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        s_valid = 1'b0; s_rs1 = '0; s_rs1_used = 1'b0; s_rs2 = '0; s_rs2_used = 1'b0;
        s_rd = '0; s_we = 1'b0; s_is_load = 1'b0; s_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        fork
            run_main();
            run_sat();
        join
        @(negedge clk); #1;
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_interlock.md
# pipeline_interlock

Parametrised hazard-interlock and forwarding-select unit for the integer pipeline. It sits beside the decode stage. It tracks the destination registers of up to DEPTH in-flight instructions between issue and writeback. Each cycle it decides whether the instruction in decode must stall, and, when forwarding is compiled in, which in-flight slot supplies each source operand. It replaces the ad-hoc register-lock wiring with one configurable block and adds a saturating stall counter for performance measurement.

## Interface
- DEPTH, 3, number of tracked in-flight slots; slot 1 is the youngest (EX) and slot DEPTH is the oldest (WB); legal range 1..7
- REG_W, 5, register specifier width
- FW, $clog2(DEPTH+1), forward-select width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  REG_W  source A specifier
- id_rs1_used  in  1  instruction reads source A
- id_rs2  in  REG_W  source B specifier
- id_rs2_used  in  1  instruction reads source B
- id_rd  in  REG_W  destination specifier
- id_we  in  1  instruction writes id_rd
- id_is_load  in  1  result is produced only at the end of the MEM stage
- flush  in  1  squash the decode instruction (taken branch or jump)
- stall  out  1  hold IF/ID and insert a bubble
- fwd_a  out  FW  source A select: 0 = register file, k = slot k
- fwd_b  out  FW  source B select, same encoding
- inflight  out  DEPTH  valid bit per slot; bit k-1 is slot k
- stall_cnt  out  16  count of stalled cycles, saturating

## Operation
- Each slot holds {valid, rd, is_load}.
- On every clock edge, slot k+1 takes slot k, for k = 1..DEPTH-1. The contents of slot DEPTH retire.
- Slot 1 loads {1, id_rd, id_is_load} when all of the following hold: id_valid, id_we, id_rd != 0, !stall and !flush. Otherwise slot 1 loads a bubble (valid = 0).
- Register 0 is hardwired zero:
  - a source of 0 never matches;
  - rd = 0 is never tracked.
- A match for a source exists when that source is used, the source is nonzero, and some valid slot holds an equal rd. The youngest matching slot (lowest k) is the one selected.
- Without forwarding:
  - stall = 1 if either source matches any slot, including slot DEPTH (the register file has no write-through);
  - fwd_a and fwd_b are always 0.
- With forwarding:
  - fwd_x = the youngest matching k for source x, or 0 if there is no match;
  - stall = 1 only if the youngest match for either source is slot 1 and that slot's is_load = 1 (load-use);
  - while stall = 1, fwd_a and fwd_b are still driven, but the datapath ignores them.
- If id_valid = 0 or flush = 1, then stall = 0 and fwd_a = fwd_b = 0.
- A flush has priority over a hazard. The squashed instruction is not tracked and is not counted as a stall.
- stall_cnt increments on each edge where stall = 1. It holds at 16'hFFFF once it reaches that value.

## Timing
- stall, fwd_a and fwd_b are combinational from the id_* inputs, flush and the slot state, all in the same cycle.
- inflight and stall_cnt are registered.
- Issue-to-slot latency is one edge. An instruction occupies slot k during the k-th cycle after it issues.
- A stall never freezes the slots. They keep shifting, so a hazard resolves without deadlock after at most DEPTH cycles.
- Reset (rst_n = 0, asynchronous):
  - all slot valid bits are cleared;
  - inflight = 0 and stall_cnt = 0, so stall = 0 and fwd_a = fwd_b = 0 whenever the id inputs are idle;
  - instructions in flight at reset are dropped with no further effect.
- If two slots hold the same rd, the youngest slot wins.

## Configuration
- PIPELINE_INTERLOCK_FWD_EN:
  - when defined, the forwarding behaviour above is used: only load-use stalls occur, and fwd_a and fwd_b select slots;
  - when undefined, every RAW hazard stalls until the producer retires, and fwd_a and fwd_b are tied to 0.

## Test plan
- Reset: assert rst_n = 0 mid-stream with 3 valid slots. Required: inflight = 0, stall_cnt = 0 and stall = 0 immediately, before the next edge.
- No FWD_EN, DEPTH = 3: issue r5 = ALU op, then present rs1 = 5. Required: stall = 1 for exactly 3 cycles, the instruction issues on the 4th, and stall_cnt = 3.
- FWD_EN: issue r5 = ALU op, then a dependent rs1 = 5. Required: stall = 0 and fwd_a = 1. A dependent op issued one cycle later gets fwd_a = 2. rs1 = 5 and rs2 = 5 together give fwd_a = fwd_b = 1.
- FWD_EN: issue load r7, then a user with rs2 = 7. Required: stall = 1 for 1 cycle, then fwd_b = 2 and issue. Repeat with r7 rewritten by a younger ALU op. Required: fwd_b selects the younger slot.
- Issue rd = 0, then rs1 = 0 with rs1_used = 1. Required: stall = 0, fwd_a = 0, and inflight bit 0 = 0.
- A hazard present together with flush = 1. Required: stall = 0, slot 1 loads a bubble, and stall_cnt is unchanged. Also hold stall for more than 65535 cycles. Required: stall_cnt saturates at 16'hFFFF.
